// File: rtl/load_store_unit.sv
// Byte-addressed load/store front end for a word-addressed data memory.
// Sub-word stores are done as read (ACCESS) then write of the merged word (MERGE).
module load_store_unit #(
    parameter int ADDR_W    = 32,
    parameter int MEM_IDX_W = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 req_valid,
    output logic                 req_ready,
    input  logic                 req_we,
    input  logic [2:0]           req_funct3,
    input  logic [ADDR_W-1:0]    req_addr,
    input  logic [31:0]          req_wdata,
    output logic                 resp_valid,
    output logic [31:0]          resp_rdata,
    output logic                 resp_err,
    output logic [MEM_IDX_W-1:0] mem_addr,
    output logic [31:0]          mem_wdata,
    output logic                 mem_we,
    input  logic [31:0]          mem_rdata
);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_ACCESS = 2'd1;
    localparam logic [1:0] S_MERGE  = 2'd2;
    localparam logic [1:0] S_RESP   = 2'd3;

    logic [1:0]        state_q, state_d;
    logic              we_q, we_d;
    logic [2:0]        f3_q, f3_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [31:0]       wdata_q, wdata_d;
    logic [31:0]       merged_q, merged_d;
    logic [31:0]       rdata_q, rdata_d;
    logic              err_q, err_d;

    logic              legal;
    logic [7:0]        byte_sel;
    logic [15:0]       half_sel;
    logic [31:0]       load_val;
    logic [31:0]       merge_val;
    logic              in_mem;
    logic              sw_access;

    // Legality is judged on the live request so the error can go straight to RESP.
    always_comb begin
        legal = 1'b0;
        case (req_funct3)
            3'b000:  legal = 1'b1;
            3'b001:  legal = ~req_addr[0];
            3'b010:  legal = (req_addr[1:0] == 2'b00);
            3'b100:  legal = ~req_we;
            3'b101:  legal = ~req_we & ~req_addr[0];
            default: legal = 1'b0;
        endcase
    end

    assign byte_sel = mem_rdata[{addr_q[1:0], 3'b000} +: 8];
    assign half_sel = addr_q[1] ? mem_rdata[31:16] : mem_rdata[15:0];

    always_comb begin
        case (f3_q)
            3'b000:  load_val = {{24{byte_sel[7]}}, byte_sel};
            3'b100:  load_val = {24'b0, byte_sel};
            3'b001:  load_val = {{16{half_sel[15]}}, half_sel};
            3'b101:  load_val = {16'b0, half_sel};
            default: load_val = mem_rdata;
        endcase
    end

    always_comb begin
        merge_val = mem_rdata;
        if (f3_q[1:0] == 2'b00)
            merge_val[{addr_q[1:0], 3'b000} +: 8] = wdata_q[7:0];
        else if (addr_q[1])
            merge_val[31:16] = wdata_q[15:0];
        else
            merge_val[15:0] = wdata_q[15:0];
    end

    always_comb begin
        state_d  = state_q;
        we_d     = we_q;
        f3_d     = f3_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        merged_d = merged_q;
        rdata_d  = rdata_q;
        err_d    = err_q;
        case (state_q)
            S_IDLE: begin
                if (req_valid) begin
                    we_d    = req_we;
                    f3_d    = req_funct3;
                    addr_d  = req_addr;
                    wdata_d = req_wdata;
                    rdata_d = 32'b0;
                    err_d   = ~legal;
                    state_d = legal ? S_ACCESS : S_RESP;
                end
            end
            S_ACCESS: begin
                if (!we_q) begin
                    rdata_d = load_val;
                    state_d = S_RESP;
                end else if (f3_q[1]) begin
                    state_d = S_RESP;
                end else begin
                    merged_d = merge_val;
                    state_d  = S_MERGE;
                end
            end
            S_MERGE: state_d = S_RESP;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= S_IDLE;
            we_q     <= 1'b0;
            f3_q     <= 3'b0;
            addr_q   <= '0;
            wdata_q  <= 32'b0;
            merged_q <= 32'b0;
            rdata_q  <= 32'b0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            we_q     <= we_d;
            f3_q     <= f3_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            merged_q <= merged_d;
            rdata_q  <= rdata_d;
            err_q    <= err_d;
        end
    end

    // Memory-side outputs decode from state only, so reset clears them at once.
    assign in_mem    = (state_q == S_ACCESS) || (state_q == S_MERGE);
    assign sw_access = (state_q == S_ACCESS) && we_q && f3_q[1];

    assign req_ready  = (state_q == S_IDLE);
    assign resp_valid = (state_q == S_RESP);
    assign resp_rdata = resp_valid ? rdata_q : 32'b0;
    assign resp_err   = resp_valid & err_q;
    assign mem_addr   = in_mem ? MEM_IDX_W'(addr_q[ADDR_W-1:2]) : '0;
    assign mem_we     = sw_access || (state_q == S_MERGE);
    assign mem_wdata  = (state_q == S_MERGE) ? merged_q :
                        sw_access            ? wdata_q  : 32'b0;

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit with a small word memory model.
module tb_load_store_unit;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_we = 1'b0;
    logic [2:0]  req_funct3 = 3'b0;
    logic [31:0] req_addr = 32'b0;
    logic [31:0] req_wdata = 32'b0;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_err;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_we;
    logic [31:0] mem_rdata;

    logic [31:0] mem [0:15];
    int checks = 0;
    int errors = 0;

    int          r_cyc, we_cnt, we_cyc, resp_cnt, acc2;
    logic [31:0] r_data, we_addr, we_data;
    logic        r_err, rdy_bad, bad_seen;

    localparam logic [31:0] INIT7 = 32'h3E820293;

    load_store_unit #(.ADDR_W(32), .MEM_IDX_W(32)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
        .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we),
        .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    assign mem_rdata = mem[mem_addr[3:0]];
    always @(posedge clk) if (mem_we) mem[mem_addr[3:0]] <= mem_wdata;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    // Issue one request at a negedge, then observe 6 cycles after the accepting edge.
    task automatic do_req(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                          input logic [31:0] wd);
        @(negedge clk);
        check("accept_ready", {31'b0, req_ready}, 32'd1);
        req_valid = 1'b1; req_we = we; req_funct3 = f3; req_addr = addr; req_wdata = wd;
        @(posedge clk);
        #1 req_valid = 1'b0;
        r_cyc = -1; r_data = 32'b0; r_err = 1'b0; we_cnt = 0; we_cyc = -1;
        we_addr = 32'b0; we_data = 32'b0; rdy_bad = 1'b0; resp_cnt = 0;
        for (int c = 1; c <= 6; c++) begin
            @(negedge clk);
            if (resp_valid) begin
                resp_cnt++;
                if (r_cyc < 0) begin
                    r_cyc = c; r_data = resp_rdata; r_err = resp_err;
                end
            end
            if (mem_we) begin
                we_cnt++;
                if (we_cyc < 0) begin
                    we_cyc = c; we_addr = mem_addr; we_data = mem_wdata;
                end
            end
            if ((r_cyc < 0 || r_cyc == c) && req_ready) rdy_bad = 1'b1;
        end
    endtask

    task automatic load_chk(input string tag, input logic [2:0] f3, input logic [31:0] addr,
                            input logic [31:0] exp);
        do_req(1'b0, f3, addr, 32'b0);
        check({tag, "_data"}, r_data, exp);
        check({tag, "_err"}, {31'b0, r_err}, 32'd0);
        check({tag, "_cyc"}, 32'(r_cyc), 32'd2);
        check({tag, "_nowe"}, 32'(we_cnt), 32'd0);
        check({tag, "_rdy"}, {31'b0, rdy_bad}, 32'd0);
        check({tag, "_npulse"}, 32'(resp_cnt), 32'd1);
    endtask

    task automatic err_chk(input string tag, input logic we, input logic [2:0] f3,
                           input logic [31:0] addr);
        do_req(we, f3, addr, 32'hFFFF_FFFF);
        check({tag, "_err"}, {31'b0, r_err}, 32'd1);
        check({tag, "_cyc"}, 32'(r_cyc), 32'd1);
        check({tag, "_data"}, r_data, 32'd0);
        check({tag, "_nowe"}, 32'(we_cnt), 32'd0);
    endtask

    task automatic store_chk(input string tag, input logic [2:0] f3, input logic [31:0] addr,
                             input logic [31:0] wd, input int exp_we_cyc,
                             input logic [31:0] exp_word);
        do_req(1'b1, f3, addr, wd);
        check({tag, "_wecnt"}, 32'(we_cnt), 32'd1);
        check({tag, "_wecyc"}, 32'(we_cyc), 32'(exp_we_cyc));
        check({tag, "_weaddr"}, we_addr, {2'b0, addr[31:2]});
        check({tag, "_wedata"}, we_data, exp_word);
        check({tag, "_rcyc"}, 32'(r_cyc), 32'(exp_we_cyc + 1));
        check({tag, "_err"}, {31'b0, r_err}, 32'd0);
        check({tag, "_rdata"}, r_data, 32'd0);
        check({tag, "_mem"}, mem[addr[5:2]], exp_word);
    endtask

    initial begin
        for (int i = 0; i < 16; i++) mem[i] = 32'b0;
        mem[7] = INIT7;
        #2;
        check("rst_ready", {31'b0, req_ready}, 32'd1);
        check("rst_rvalid", {31'b0, resp_valid}, 32'd0);
        check("rst_rdata", resp_rdata, 32'd0);
        check("rst_err", {31'b0, resp_err}, 32'd0);
        check("rst_maddr", mem_addr, 32'd0);
        check("rst_mwdata", mem_wdata, 32'd0);
        check("rst_mwe", {31'b0, mem_we}, 32'd0);
        repeat (2) @(negedge clk);
        rst = 1'b0;

        load_chk("lb1c", 3'b000, 32'h1C, 32'hFFFFFF93);
        load_chk("lbu1f", 3'b100, 32'h1F, 32'h0000003E);
        load_chk("lh1e", 3'b001, 32'h1E, 32'h00003E82);
        load_chk("lw1c", 3'b010, 32'h1C, 32'h3E820293);
        load_chk("lb1e", 3'b000, 32'h1E, 32'hFFFFFF82);
        load_chk("lhu1c", 3'b101, 32'h1C, 32'h00000293);

        store_chk("sb1d", 3'b000, 32'h1D, 32'h000000AB, 2, 32'h3E82AB93);
        load_chk("lw_after_sb", 3'b010, 32'h1C, 32'h3E82AB93);
        mem[7] = INIT7;
        store_chk("sh1c", 3'b001, 32'h1C, 32'hFFFFBEEF, 2, 32'h3E82BEEF);
        mem[7] = INIT7;
        store_chk("sw1c", 3'b010, 32'h1C, 32'h11223344, 1, 32'h11223344);
        mem[7] = INIT7;

        err_chk("sw1a", 1'b1, 3'b010, 32'h1A);
        err_chk("lh1f", 1'b0, 3'b001, 32'h1F);
        err_chk("ld011", 1'b0, 3'b011, 32'h1C);
        err_chk("st100", 1'b1, 3'b100, 32'h1C);
        check("err_mem7", mem[7], INIT7);

        // Reset mid-way through a half-word store.
        @(negedge clk);
        req_valid = 1'b1; req_we = 1'b1; req_funct3 = 3'b001; req_addr = 32'h1E;
        req_wdata = 32'h00001234;
        @(posedge clk);
        #1 req_valid = 1'b0;
        #2 rst = 1'b1;
        #1;
        check("rstsh_mwe", {31'b0, mem_we}, 32'd0);
        check("rstsh_ready", {31'b0, req_ready}, 32'd1);
        check("rstsh_rvalid", {31'b0, resp_valid}, 32'd0);
        check("rstsh_maddr", mem_addr, 32'd0);
        #1 rst = 1'b0;
        bad_seen = 1'b0;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            if (resp_valid || mem_we) bad_seen = 1'b1;
        end
        check("rstsh_quiet", {31'b0, bad_seen}, 32'd0);
        check("rstsh_mem7", mem[7], INIT7);
        load_chk("lw_after_rst", 3'b010, 32'h1C, 32'h3E820293);

        // Back-to-back with req_valid held: SW then LB.
        @(negedge clk);
        req_valid = 1'b1; req_we = 1'b1; req_funct3 = 3'b010; req_addr = 32'h18;
        req_wdata = 32'hCAFEF00D;
        @(posedge clk);
        #1 req_we = 1'b0; req_funct3 = 3'b000; req_addr = 32'h1B; req_wdata = 32'b0;
        acc2 = -1; resp_cnt = 0; r_data = 32'b0;
        for (int c = 1; c <= 8; c++) begin
            @(negedge clk);
            if (resp_valid) begin
                resp_cnt++;
                r_data = resp_rdata;
            end
            if (req_ready && acc2 < 0) begin
                acc2 = c;
                @(posedge clk);
                #1 req_valid = 1'b0;
            end
        end
        req_valid = 1'b0;
        check("b2b_accept2", 32'(acc2), 32'd3);
        check("b2b_pulses", 32'(resp_cnt), 32'd2);
        check("b2b_lb_data", r_data, 32'hFFFFFFCA);
        check("b2b_mem6", mem[6], 32'hCAFEF00D);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
